fetch_pc_unit: RTL
==================

// Module: fetch_pc_unit
// PURPOSE
//  Program-counter register and fetch sequencer for the WISC-F18 core; sits directly
//  upstream of PC_control. Holds the architectural PC, supplies it to instruction memory
//  and as PC_in to PC_control, and accepts PC_control's redirect target. Handles stalls,
//  taken-branch redirects, HLT detection and a fetched-instruction counter.
// PARAMETERS
//  RESET_PC     16'h0000  PC value loaded by reset
//  PC_INC       2         byte increment per sequential fetch (16-bit instructions)
//  HALT_OPCODE  4'hF      instr[15:12] value that identifies HLT
// PORTS
//  clk             in   1   rising-edge clock
//  rst             in   1   synchronous reset, active-high
//  stall           in   1   hazard unit: hold PC, no fetch accepted this cycle
//  branch_taken    in   1   redirect request (PC_control result differs from pc_plus2)
//  branch_target   in   16  redirect address (PC_control PC_out)
//  instr           in   16  imem data for address pc (combinational read, same cycle)
//  pc              out  16  current PC; drives imem address and PC_control PC_in
//  pc_plus2        out  16  pc + PC_INC, combinational, mod 2^16
//  fetch_valid     out  1   instr at pc is a real fetch this cycle (RUN, !stall, !branch_taken)
//  halted          out  1   registered; 1 while FSM in HALTED
//  fetch_count     out  16  number of accepted fetches, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc<=RESET_PC, state<=RUN, halted<=0, fetch_count<=0.
//   rst overrides every other input; reset mid-halt or mid-stall returns to RUN at RESET_PC.
//  FSM states: RUN, HALTED.
//  RUN, per posedge, priority order:
//   1. branch_taken=1 -> pc<=branch_target; state stays RUN; no fetch counted (flush).
//      Wins over stall and over HLT in instr (older branch squashes younger fetch).
//   2. stall=1 -> pc holds; no fetch counted; HLT in instr ignored this cycle.
//   3. instr[15:12]==HALT_OPCODE -> pc holds (HLT address); state<=HALTED; fetch counted.
//   4. else -> pc<=pc_plus2; fetch counted.
//  HALTED:
//   - pc holds; fetch_valid=0; fetch_count holds; halted=1 (from the cycle after HLT fetch).
//   - branch_taken=1 (older in-flight branch resolved taken) -> pc<=branch_target,
//     state<=RUN, halted<=0 next cycle. stall ignored in HALTED.
//  fetch_valid = (state==RUN) & !stall & !branch_taken; combinational.
//  fetch_count increments by 1 on each posedge where fetch_valid=1; at 16'hFFFF it holds.
//  Arithmetic: pc_plus2 = pc + PC_INC truncated to 16 bits; 16'hFFFE -> 16'h0000.
//  branch_target taken as-is, no alignment check (odd targets pass through).
//  Latency: redirect visible on pc one cycle after branch_taken sampled; no bubbles inserted
//   beyond the flushed cycle.
//  No X on any output after the first reset edge; inputs are don't-care while rst=1.
// TESTING
//  1 Reset, then 4 cycles NOP instr (16'h0000), no stall -> pc 0,2,4,6,8; fetch_count=4.
//  2 pc=16'h0010, stall=1 for 3 cycles -> pc stays 16'h0010, fetch_count unchanged,
//    fetch_valid=0; release -> pc=16'h0012 next cycle.
//  3 pc=16'h0020, branch_taken=1, target=16'h0100, stall=1 same cycle -> pc=16'h0100 next
//    cycle; fetch_count unchanged.
//  4 instr=16'hF000 at pc=16'h0030 -> halted=1 next cycle, pc stays 16'h0030 for 5 cycles;
//    then branch_taken, target=16'h0040 -> pc=16'h0040, halted=0, fetching resumes.
//  5 HLT in instr with branch_taken=1 same cycle, target=16'h0200 -> no halt, pc=16'h0200.
//  6 Force pc=16'hFFFE via branch, NOP -> pc=16'h0000; assert rst while halted -> pc=RESET_PC,
//    halted=0, fetch_count=0 next cycle.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer for the WISC-F18 core: holds the architectural PC,
// applies stalls and taken-branch redirects, detects HLT and counts accepted fetches.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned PC_INC      = 2,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] instr,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        fetch_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] count_q;
  logic        is_hlt;

  assign is_hlt   = (instr[15:12] == HALT_OPCODE);
  assign pc_plus2 = pc_q + 16'(PC_INC);

  // Older branch squashes the younger fetch, so redirect outranks both stall and HLT.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_valid = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          pc_d = branch_target;
        end else if (!stall) begin
          fetch_valid = 1'b1;
          if (is_hlt) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_plus2;
          end
        end
      end
      HALTED: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (fetch_valid && (count_q != '1)) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign pc          = pc_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = count_q;

endmodule
